requant_drain_ctrl: RTL and testbench
=====================================

# requant_drain_ctrl

Sequencer that drains int32 accumulator rows from the 128-bit C global buffer after a TPU run. It requantizes each of the four lanes to int8 using fixed-point rescale (saturating rounding doubling high multiply, then rounding divide by power of two), adds the output offset and clamps. It packs each row into one 32-bit word and writes it to an output buffer. It sits between the C buffer's TPU-side port and the output buffer, and is started by a CFU command once TPU `busy` falls.

## Interface
Parameters:
- ADDR_BITS, 14, buffer index width
- RESCALE_LAT, 4, start-to-done latency of the rescale sub-module

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle launch pulse
- row_count  in  ADDR_BITS  rows to drain
- c_base  in  ADDR_BITS  first C row
- o_base  in  ADDR_BITS  first output word
- multiplier  in  32  signed quantized multiplier
- shift  in  5  right-shift amount, 0..31
- output_offset  in  32  signed
- act_min, act_max  in  8 each  signed clamp bounds
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- c_index  out  ADDR_BITS  C read index (1-cycle registered-read BRAM)
- c_data  in  128  C row; lane i = bits [32i+31:32i]
- o_wr_en  out  1  output write strobe
- o_index  out  ADDR_BITS  output write index
- o_data  out  32  packed int8; lane i at [8i+7:8i]

## Operation
- States: IDLE, RD, CAP, LANE, WR, DONE.
- IDLE:
  - start=1 latches all config inputs into internal registers and clears the row counter r.
  - If row_count==0, go to DONE; otherwise go to RD.
  - start outside IDLE is ignored.
- RD: c_index = c_base + r (mod 2^ADDR_BITS); go to CAP.
- CAP: capture c_data into the row register; set lane=0; go to LANE.
- LANE:
  - Pulse the rescale start for the current lane and wait for rescale done.
  - On done, store the int8 result into byte `lane`.
  - After lane 3, go to WR; otherwise lane+1 and re-pulse start.
- WR:
  - o_wr_en=1, o_index = o_base + r (mod 2^ADDR_BITS), o_data = packed row.
  - Increment r. If r == row_count, go to DONE; otherwise go to RD.
- DONE: done=1, busy=0; go to IDLE.
- Rescale arithmetic (per lane, x = acc):
  - SRDHM: if x == multiplier == 0x80000000, the result is 0x7FFFFFFF.
  - Otherwise ab = x·multiplier as a 64-bit signed product; nudge = 2^30 if ab ≥ 0, else 1−2^30.
  - SRDHM result = (ab+nudge)/2^31, truncated toward zero.
  - RDBPOT: mask = 2^shift−1, rem = y & mask, thr = (mask>>1) + (y<0).
  - RDBPOT result = (y >>> shift) + (rem > thr), with the comparison signed.
  - Add output_offset with 32-bit wrap, clamp to [act_min, act_max], truncate to 8 bits.
- Config inputs are sampled only at start; later changes have no effect.

## Timing
- Reset values: busy=0, done=0, o_wr_en=0, c_index=0, o_index=0, o_data=0; state IDLE; rescale sub-module idle.
- Start is sampled in cycle 0; RD occupies cycle 1.
- Per row: RD 1 + CAP 1 + 4×(RESCALE_LAT+1) + WR 1 = 23 cycles.
- Lane timing: rescale done arrives RESCALE_LAT cycles after start; the next lane's start comes in the cycle after done.
- o_wr_en for row k (0-based) is high in cycle 23(k+1).
- done is high in cycle 23·row_count + 1; for row_count=0, done is high in cycle 1.
- busy is high from cycle 1 through the WR of the last row, and is low in the DONE cycle.
- Index wrap: c_base + r and o_base + r wrap modulo 2^ADDR_BITS.
- Reset mid-operation (rst_n low at any edge):
  - Next cycle: IDLE, all outputs at reset values.
  - Any in-flight row is discarded with no write; the rescale unit is flushed.
- start and rst_n low at the same edge: reset wins.

## Structure
- Package requant_pkg holds:
  - state enum;
  - INT32_MIN, INT32_MAX;
  - NUDGE_POS, NUDGE_NEG;
  - RESCALE_LAT default.
- Sub-module fixed_point_rescale:
  - Inputs: acc, multiplier, shift, output_offset, act_min, act_max, start.
  - Outputs: done and int8 result.
  - Fixed RESCALE_LAT-cycle pipeline: multiply, nudge, round-shift, offset/clamp.
- The controller owns the FSM, counters, row register and packing only.

## Test plan
- Basic lane math:
  - Stimulus: lanes [100, −100, 7, 0], multiplier 0x40000000, shift 1, offset −3, clamp [−128,127], row_count 1.
  - Expected: one write, o_data=0xFDFFE416, at cycle 23; done at cycle 24.
- Overflow path:
  - Stimulus: lane 0 acc=0x80000000, multiplier 0x80000000, shift 31, offset 0.
  - Expected: byte 0 = 0x01.
- Clamping:
  - Stimulus: lanes [1000, −1000, 5, −5], multiplier 0x7FFFFFFF, shift 0, offset 0, clamp [−10,10].
  - Expected: o_data = 0xFB05F60A.
- Wrap and cadence:
  - Stimulus: row_count 3, c_base 0x3FFF, o_base 0x3FFE.
  - Expected: c_index sequence 0x3FFF, 0x0000, 0x0001; o_index sequence 0x3FFE, 0x3FFF, 0x0000.
  - Expected: o_wr_en in cycles 23, 46 and 69; done in cycle 70.
- Start handling:
  - Stimulus: row_count=0.
  - Expected: done in cycle 1, no write.
  - Stimulus: a second start pulse while busy.
  - Expected: ignored, write count unchanged.
- Reset mid-run:
  - Stimulus: rst_n low for one cycle during LANE of row 1 of 3.
  - Expected: busy=0 next cycle, exactly one write total, and a fresh start afterwards completes normally.

Source files
------------

// File: rtl/requant_pkg.sv
// Shared types and constants for the requantizing C-buffer drain sequencer.
package requant_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_LANE,
      S_WR,
      S_DONE
   } state_t;

   localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
   localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;

   // Rounding nudges for the doubling high multiply: 2^30 and 1 - 2^30.
   localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
   localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;

   localparam int RESCALE_LAT_DEFAULT = 4;

endpackage

// File: rtl/fixed_point_rescale.sv
// Per-lane int32 -> int8 requantizer: SRDHM, rounding shift, offset and clamp.
// Arithmetic occupies four stages; done follows start by exactly RESCALE_LAT (>= 4) cycles.
module fixed_point_rescale
   import requant_pkg::*;
#(
   parameter int RESCALE_LAT = RESCALE_LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [31:0] i_acc,
   input  logic [31:0] i_multiplier,
   input  logic [4:0]  i_shift,
   input  logic [31:0] i_output_offset,
   input  logic [7:0]  i_act_min,
   input  logic [7:0]  i_act_max,
   output logic        o_done,
   output logic [7:0]  o_result
);

   function automatic logic signed [31:0] srdhm_round(input logic signed [63:0] ab,
                                                       input logic              ovf);
      logic signed [63:0] s;
      logic signed [31:0] q;
      s = ab + ((ab >= 64'sd0) ? NUDGE_POS : NUDGE_NEG);
      q = s[62:31];
      // Floor from the slice; bump toward zero when a negative sum has a fraction.
      if (s < 64'sd0 && s[30:0] != '0) q = q + 32'sd1;
      return ovf ? INT32_MAX : q;
   endfunction

   function automatic logic signed [31:0] rdbpot(input logic signed [31:0] y,
                                                  input logic [4:0]         sh);
      logic signed [31:0] mask;
      logic signed [31:0] rem;
      logic signed [31:0] thr;
      mask = (32'sd1 <<< sh) - 32'sd1;
      rem  = y & mask;
      thr  = (mask >>> 1) + ((y < 32'sd0) ? 32'sd1 : 32'sd0);
      return (y >>> sh) + ((rem > thr) ? 32'sd1 : 32'sd0);
   endfunction

   function automatic logic [7:0] offset_clamp(input logic signed [31:0] y,
                                               input logic signed [31:0] off,
                                               input logic signed [7:0]  lo,
                                               input logic signed [7:0]  hi);
      logic signed [31:0] v;
      logic signed [31:0] lo32;
      logic signed [31:0] hi32;
      lo32 = {{24{lo[7]}}, lo};
      hi32 = {{24{hi[7]}}, hi};
      v    = y + off;
      if (v < lo32)      v = lo32;
      else if (v > hi32) v = hi32;
      return v[7:0];
   endfunction

   logic signed [63:0]     w_acc64;
   logic signed [63:0]     w_mult64;
   logic signed [63:0]     r_prod_p0;
   logic                   r_ovf_p0;
   logic signed [31:0]     r_srdhm_p1;
   logic signed [31:0]     r_rdbpot_p2;
   logic [7:0]             r_res_p3;
   logic [RESCALE_LAT-1:0] r_vld_p;

   assign w_acc64  = {{32{i_acc[31]}}, i_acc};
   assign w_mult64 = {{32{i_multiplier[31]}}, i_multiplier};

   always_ff @(posedge clk) begin
      if (!rst_n) r_vld_p <= '0;
      else        r_vld_p <= {r_vld_p[RESCALE_LAT-2:0], i_start};
   end

   always_ff @(posedge clk) begin
      // p0: full product and the single overflowing operand pair
      if (i_start) begin
         r_prod_p0 <= w_acc64 * w_mult64;
         r_ovf_p0  <= (i_acc == INT32_MIN) && (i_multiplier == INT32_MIN);
      end
      // p1: nudged high half; p2: rounding shift; p3: offset and clamp
      if (r_vld_p[0]) r_srdhm_p1  <= srdhm_round(r_prod_p0, r_ovf_p0);
      if (r_vld_p[1]) r_rdbpot_p2 <= rdbpot(r_srdhm_p1, i_shift);
      if (r_vld_p[2]) r_res_p3    <= offset_clamp(r_rdbpot_p2, i_output_offset,
                                                  i_act_min, i_act_max);
   end

   // Only one lane is in flight, so p3 stays stable until the trailing valid arrives.
   assign o_done   = r_vld_p[RESCALE_LAT-1];
   assign o_result = r_res_p3;

endmodule

// File: rtl/requant_drain_ctrl.sv
// Drains int32 accumulator rows from the C buffer, requantizes four lanes per row
// through fixed_point_rescale and writes one packed int8 word per row.
module requant_drain_ctrl
   import requant_pkg::*;
#(
   parameter int ADDR_BITS   = 14,
   parameter int RESCALE_LAT = RESCALE_LAT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] row_count,
   input  logic [ADDR_BITS-1:0] c_base,
   input  logic [ADDR_BITS-1:0] o_base,
   input  logic [31:0]          multiplier,
   input  logic [4:0]           shift,
   input  logic [31:0]          output_offset,
   input  logic [7:0]           act_min,
   input  logic [7:0]           act_max,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITS-1:0] c_index,
   input  logic [127:0]         c_data,
   output logic                 o_wr_en,
   output logic [ADDR_BITS-1:0] o_index,
   output logic [31:0]          o_data
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDR_BITS-1:0] r_row;
   logic [ADDR_BITS-1:0] w_row_inc;
   logic [1:0]           r_lane;
   logic                 r_issue;
   logic [ADDR_BITS-1:0] r_cnt;
   logic [ADDR_BITS-1:0] r_cbase;
   logic [ADDR_BITS-1:0] r_obase;
   logic [31:0]          r_mult;
   logic [4:0]           r_shift;
   logic [31:0]          r_off;
   logic [7:0]           r_min;
   logic [7:0]           r_max;
   logic [127:0]         r_cdata;
   logic [31:0]          r_pack;
   logic                 w_rs_start;
   logic                 w_rs_done;
   logic [7:0]           w_rs_result;
   logic [31:0]          w_acc;

   assign w_row_inc = r_row + 1'b1;
   assign w_acc     = r_cdata[{r_lane, 5'b00000} +: 32];

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = (row_count == '0) ? S_DONE : S_RD;
         S_RD:    w_state_nxt = S_CAP;
         S_CAP:   w_state_nxt = S_LANE;
         S_LANE:  if (w_rs_done && r_lane == 2'd3) w_state_nxt = S_WR;
         S_WR:    w_state_nxt = (w_row_inc == r_cnt) ? S_DONE : S_RD;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Indices and data are forced to zero outside their strobe states.
   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      c_index    = '0;
      o_wr_en    = 1'b0;
      o_index    = '0;
      o_data     = '0;
      w_rs_start = 1'b0;
      case (r_state)
         S_RD: begin
            busy    = 1'b1;
            c_index = r_cbase + r_row;
         end
         S_CAP:  busy = 1'b1;
         S_LANE: begin
            busy       = 1'b1;
            w_rs_start = r_issue;
         end
         S_WR: begin
            busy    = 1'b1;
            o_wr_en = 1'b1;
            o_index = r_obase + r_row;
            o_data  = r_pack;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_row   <= '0;
         r_lane  <= '0;
         r_issue <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) r_row <= '0;
            S_CAP: begin
               r_lane  <= '0;
               r_issue <= 1'b1;
            end
            S_LANE: begin
               if (r_issue) r_issue <= 1'b0;
               if (w_rs_done && r_lane != 2'd3) begin
                  r_lane  <= r_lane + 2'd1;
                  r_issue <= 1'b1;
               end
            end
            S_WR:    r_row <= w_row_inc;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && start) begin
         r_cnt   <= row_count;
         r_cbase <= c_base;
         r_obase <= o_base;
         r_mult  <= multiplier;
         r_shift <= shift;
         r_off   <= output_offset;
         r_min   <= act_min;
         r_max   <= act_max;
      end
      if (r_state == S_CAP) r_cdata <= c_data;
      if (r_state == S_LANE && w_rs_done) r_pack[{r_lane, 3'b000} +: 8] <= w_rs_result;
   end

   fixed_point_rescale #(
      .RESCALE_LAT(RESCALE_LAT)
   ) u_rescale (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_start        (w_rs_start),
      .i_acc          (w_acc),
      .i_multiplier   (r_mult),
      .i_shift        (r_shift),
      .i_output_offset(r_off),
      .i_act_min      (r_min),
      .i_act_max      (r_max),
      .o_done         (w_rs_done),
      .o_result       (w_rs_result)
   );

endmodule

// File: tb/tb_requant_drain_ctrl.sv
// Directed bench for requant_drain_ctrl with hand-computed rows, indices and cycle numbers.
module tb_requant_drain_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [13:0]  row_count = '0;
   logic [13:0]  c_base = '0;
   logic [13:0]  o_base = '0;
   logic [31:0]  multiplier = '0;
   logic [4:0]   shift = '0;
   logic [31:0]  output_offset = '0;
   logic [7:0]   act_min = '0;
   logic [7:0]   act_max = '0;
   logic         busy;
   logic         done;
   logic [13:0]  c_index;
   logic [127:0] c_data = '0;
   logic         o_wr_en;
   logic [13:0]  o_index;
   logic [31:0]  o_data;

   logic [127:0] cmem [0:16383];

   int           n_chk = 0;
   int           n_fail = 0;

   int           wr_n;
   int           wr_cyc [8];
   logic [13:0]  wr_idx [8];
   logic [31:0]  wr_dat [8];
   logic         wr_busy [8];
   logic [13:0]  cidx [4];
   int           done_cyc;
   logic         busy1;
   logic         busy_at_done;
   logic [62:0]  rst_snap;

   requant_drain_ctrl #(
      .ADDR_BITS  (14),
      .RESCALE_LAT(4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .row_count    (row_count),
      .c_base       (c_base),
      .o_base       (o_base),
      .multiplier   (multiplier),
      .shift        (shift),
      .output_offset(output_offset),
      .act_min      (act_min),
      .act_max      (act_max),
      .busy         (busy),
      .done         (done),
      .c_index      (c_index),
      .c_data       (c_data),
      .o_wr_en      (o_wr_en),
      .o_index      (o_index),
      .o_data       (o_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) c_data <= cmem[c_index];

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_cfg(input logic [13:0] cb, input logic [13:0] ob, input logic [31:0] m,
                          input logic [4:0] sh, input logic [31:0] off,
                          input logic [7:0] mn, input logic [7:0] mx);
      c_base        = cb;
      o_base        = ob;
      multiplier    = m;
      shift         = sh;
      output_offset = off;
      act_min       = mn;
      act_max       = mx;
   endtask

   // Cycle 0 is the cycle start is high; every later negedge advances one cycle.
   task automatic run(input int rc, input int rst_at, input int restart_at, input int max_cyc);
      int cyc;
      wr_n         = 0;
      done_cyc     = -1;
      busy1        = 1'b0;
      busy_at_done = 1'b1;
      rst_snap     = '1;
      for (int k = 0; k < 4; k++) cidx[k] = '1;
      row_count = rc[13:0];
      @(negedge clk);
      start = 1'b1;
      cyc   = 0;
      while (cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         rst_n = 1'b1;
         if (cyc == 1) busy1 = busy;
         for (int k = 0; k < 4; k++) if (cyc == 23 * k + 1) cidx[k] = c_index;
         if (o_wr_en) begin
            if (wr_n < 8) begin
               wr_cyc[wr_n]  = cyc;
               wr_idx[wr_n]  = o_index;
               wr_dat[wr_n]  = o_data;
               wr_busy[wr_n] = busy;
            end
            wr_n++;
         end
         if (done && done_cyc < 0) begin
            done_cyc     = cyc;
            busy_at_done = busy;
         end
         if (cyc == rst_at + 1) rst_snap = {busy, done, o_wr_en, c_index, o_index, o_data};
         if (cyc == restart_at) begin
            start      = 1'b1;
            row_count  = 14'd5;
            multiplier = 32'h0000_0001;
         end
         if (cyc == rst_at) rst_n = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) cmem[i] = '0;
      cmem[14'h0010] = {32'h0000_0000, 32'h0000_0007, 32'hFFFF_FF9C, 32'h0000_0064};
      cmem[14'h0100] = {32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
      cmem[14'h0200] = {32'hFFFF_FFFB, 32'h0000_0005, 32'hFFFF_FC18, 32'h0000_03E8};
      cmem[14'h3FFF] = {32'h0000_0000, 32'h0000_0007, 32'hFFFF_FF9C, 32'h0000_0064};
      cmem[14'h0000] = '0;
      cmem[14'h0001] = {32'h0000_03E8, 32'h0000_00C8, 32'hFFFF_FFFA, 32'h0000_0004};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_eq("reset_busy",    busy,    1'b0);
      chk_eq("reset_done",    done,    1'b0);
      chk_eq("reset_wr_en",   o_wr_en, 1'b0);
      chk_eq("reset_c_index", c_index, 14'd0);
      chk_eq("reset_o_index", o_index, 14'd0);
      chk_eq("reset_o_data",  o_data,  32'd0);
      rst_n = 1'b1;

      set_cfg(14'h0010, 14'h0020, 32'h4000_0000, 5'd1, 32'hFFFF_FFFD, 8'h80, 8'h7F);
      run(1, -1, -1, 40);
      chk_eq("basic_c_index",   cidx[0],      14'h0010);
      chk_eq("basic_busy_c1",   busy1,        1'b1);
      chk_eq("basic_wr_count",  wr_n,         1);
      chk_eq("basic_wr_cycle",  wr_cyc[0],    23);
      chk_eq("basic_o_index",   wr_idx[0],    14'h0020);
      chk_eq("basic_o_data",    wr_dat[0],    32'hFDFF_E416);
      chk_eq("basic_busy_wr",   wr_busy[0],   1'b1);
      chk_eq("basic_done_cyc",  done_cyc,     24);
      chk_eq("basic_busy_done", busy_at_done, 1'b0);

      set_cfg(14'h0100, 14'h0005, 32'h8000_0000, 5'd31, 32'h0000_0000, 8'h80, 8'h7F);
      run(1, -1, -1, 40);
      chk_eq("ovf_wr_count", wr_n,      1);
      chk_eq("ovf_o_data",   wr_dat[0], 32'h0000_0001);

      set_cfg(14'h0200, 14'h0006, 32'h7FFF_FFFF, 5'd0, 32'h0000_0000, 8'hF6, 8'h0A);
      run(1, -1, -1, 40);
      chk_eq("clamp_o_data", wr_dat[0], 32'hFB05_F60A);

      set_cfg(14'h3FFF, 14'h3FFE, 32'h4000_0000, 5'd1, 32'hFFFF_FFFD, 8'h80, 8'h7F);
      run(3, -1, -1, 100);
      chk_eq("wrap_c_index0", cidx[0],   14'h3FFF);
      chk_eq("wrap_c_index1", cidx[1],   14'h0000);
      chk_eq("wrap_c_index2", cidx[2],   14'h0001);
      chk_eq("wrap_wr_count", wr_n,      3);
      chk_eq("wrap_wr_cyc0",  wr_cyc[0], 23);
      chk_eq("wrap_wr_cyc1",  wr_cyc[1], 46);
      chk_eq("wrap_wr_cyc2",  wr_cyc[2], 69);
      chk_eq("wrap_o_index0", wr_idx[0], 14'h3FFE);
      chk_eq("wrap_o_index1", wr_idx[1], 14'h3FFF);
      chk_eq("wrap_o_index2", wr_idx[2], 14'h0000);
      chk_eq("wrap_o_data0",  wr_dat[0], 32'hFDFF_E416);
      chk_eq("wrap_o_data1",  wr_dat[1], 32'hFDFD_FDFD);
      chk_eq("wrap_o_data2",  wr_dat[2], 32'h7F2F_FBFE);
      chk_eq("wrap_done_cyc", done_cyc,  70);

      run(0, -1, -1, 30);
      chk_eq("zero_done_cyc", done_cyc, 1);
      chk_eq("zero_wr_count", wr_n,     0);

      set_cfg(14'h0010, 14'h0020, 32'h4000_0000, 5'd1, 32'hFFFF_FFFD, 8'h80, 8'h7F);
      run(1, -1, 10, 60);
      chk_eq("restart_wr_count", wr_n,      1);
      chk_eq("restart_o_data",   wr_dat[0], 32'hFDFF_E416);
      chk_eq("restart_done_cyc", done_cyc,  24);

      set_cfg(14'h3FFF, 14'h3FFE, 32'h4000_0000, 5'd1, 32'hFFFF_FFFD, 8'h80, 8'h7F);
      run(3, 30, -1, 100);
      chk_eq("midrst_outputs",  rst_snap,  63'd0);
      chk_eq("midrst_wr_count", wr_n,      1);
      chk_eq("midrst_o_data",   wr_dat[0], 32'hFDFF_E416);
      chk_eq("midrst_no_done",  done_cyc,  -1);

      set_cfg(14'h0010, 14'h0020, 32'h4000_0000, 5'd1, 32'hFFFF_FFFD, 8'h80, 8'h7F);
      run(1, -1, -1, 40);
      chk_eq("after_rst_wr_cyc",   wr_cyc[0], 23);
      chk_eq("after_rst_o_data",   wr_dat[0], 32'hFDFF_E416);
      chk_eq("after_rst_done_cyc", done_cyc,  24);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
